// File: rtl/captador_serie_4bits_pkg.sv
// Shared types and constants for the serial-in front end of the 4-bit load register.
package captador_pkg;

   typedef enum logic [1:0] {
      REPOSO   = 2'd0,
      RECIBIR  = 2'd1,
      PARIDAD  = 2'd2,
      ENTREGAR = 2'd3
   } estado_t;

   localparam int ANCHO_DATO        = 4;
   localparam int ANCHO_CONT_BITS   = $clog2(ANCHO_DATO);
   // Wide enough for a reload value of up to 16 cycles per bit (0..15).
   localparam int ANCHO_CONT_CICLOS = 4;

endpackage

// File: rtl/captador_serie_4bits_if.sv
// Serial line, strobe and word/load outputs of captador_serie_4bits.
interface captador_serie_4bits_if;
   import captador_pkg::*;

   logic                  habilitar;
   logic                  inicio;
   logic                  dato_serie;
   logic [ANCHO_DATO-1:0] datos;
   logic                  carga;
   logic                  ocupado;
   logic                  error;

   modport master (
      output habilitar, inicio, dato_serie,
      input  datos, carga, ocupado, error
   );

   modport slave (
      input  habilitar, inicio, dato_serie,
      output datos, carga, ocupado, error
   );

endinterface

// File: rtl/captador_serie_4bits_contador_tiempo_bit.sv
// Bit-period down-counter: reloads CICLOS_POR_BIT-1 on load or terminal count.
module contador_tiempo_bit
   import captador_pkg::*;
#(
   parameter int CICLOS_POR_BIT = 1
) (
   input  logic reloj,
   input  logic reinicio_n,
   input  logic cargar,
   input  logic contar,
   output logic fin
);

   localparam logic [ANCHO_CONT_CICLOS-1:0] RECARGA = ANCHO_CONT_CICLOS'(CICLOS_POR_BIT - 1);

   logic [ANCHO_CONT_CICLOS-1:0] cuenta;

   always_ff @(posedge reloj) begin
      if (!reinicio_n) begin
         cuenta <= '0;
      end else if (cargar || (contar && fin)) begin
         cuenta <= RECARGA;
      end else if (contar) begin
         cuenta <= cuenta - 1'b1;
      end
   end

   assign fin = (cuenta == '0);

endmodule

// File: rtl/captador_serie_4bits.sv
// Serial-to-4-bit front end with one-cycle load pulse.
// Optional even-parity fifth bit enabled by defining CAPTADOR_PARIDAD_EN.
module captador_serie_4bits
   import captador_pkg::*;
#(
   parameter int CICLOS_POR_BIT = 1,
   parameter int LSB_PRIMERO    = 1
) (
   input  logic                 reloj,
   input  logic                 reinicio_n,
   captador_serie_4bits_if.slave bus
);

   estado_t                    estado, estado_sig;
   logic [ANCHO_CONT_BITS-1:0] cont_bits;
   logic [ANCHO_DATO-1:0]      desplaz, desplaz_sig;
   logic [ANCHO_DATO-1:0]      datos_q;
   logic                       fin_bit;
   logic                       cargar_ctr;
   logic                       contar;
   logic                       muestrear;

   contador_tiempo_bit #(.CICLOS_POR_BIT(CICLOS_POR_BIT)) u_contador (
      .reloj      (reloj),
      .reinicio_n (reinicio_n),
      .cargar     (cargar_ctr),
      .contar     (contar),
      .fin        (fin_bit)
   );

   always_comb begin
      estado_sig = estado;
      cargar_ctr = 1'b0;
      contar     = 1'b0;
      if (bus.habilitar) begin
         case (estado)
            REPOSO: begin
               if (bus.inicio) begin
                  estado_sig = RECIBIR;
                  cargar_ctr = 1'b1;
               end
            end
            RECIBIR: begin
               contar = 1'b1;
               if (fin_bit && (cont_bits == ANCHO_CONT_BITS'(ANCHO_DATO - 1))) begin
`ifdef CAPTADOR_PARIDAD_EN
                  estado_sig = PARIDAD;
`else
                  estado_sig = ENTREGAR;
`endif
               end
            end
`ifdef CAPTADOR_PARIDAD_EN
            PARIDAD: begin
               contar = 1'b1;
               if (fin_bit) begin
                  estado_sig = (bus.dato_serie == ^desplaz) ? ENTREGAR : REPOSO;
               end
            end
`endif
            ENTREGAR: estado_sig = REPOSO;
            default:  estado_sig = REPOSO;
         endcase
      end
   end

   always_comb begin
      desplaz_sig = desplaz;
      if (LSB_PRIMERO != 0) begin
         desplaz_sig = {bus.dato_serie, desplaz[ANCHO_DATO-1:1]};
      end else begin
         desplaz_sig = {desplaz[ANCHO_DATO-2:0], bus.dato_serie};
      end
   end

   assign muestrear = contar && fin_bit && (estado == RECIBIR);

   // The output word is latched on entry to ENTREGAR so it is already valid
   // during the carga cycle; from RECIBIR that includes the bit being sampled.
   always_ff @(posedge reloj) begin
      if (!reinicio_n) begin
         estado    <= REPOSO;
         cont_bits <= '0;
         desplaz   <= '0;
         datos_q   <= '0;
      end else begin
         estado <= estado_sig;
         if (cargar_ctr) begin
            cont_bits <= '0;
         end else if (muestrear) begin
            cont_bits <= cont_bits + 1'b1;
            desplaz   <= desplaz_sig;
         end
         if ((estado_sig == ENTREGAR) && (estado != ENTREGAR)) begin
            datos_q <= (estado == RECIBIR) ? desplaz_sig : desplaz;
         end
      end
   end

   assign bus.datos   = datos_q;
   assign bus.carga   = bus.habilitar && (estado == ENTREGAR);
   assign bus.ocupado = (estado != REPOSO);

`ifdef CAPTADOR_PARIDAD_EN
   logic error_q;

   always_ff @(posedge reloj) begin
      if (!reinicio_n) begin
         error_q <= 1'b0;
      end else if (bus.habilitar) begin
         error_q <= (estado == PARIDAD) && fin_bit && (bus.dato_serie != ^desplaz);
      end
   end

   assign bus.error = error_q && bus.habilitar;
`else
   assign bus.error = 1'b0;
`endif

endmodule
